alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream command sequencer for the 8-bit sequential ALU (add/sub/Booth mul/div).
//  Accepts one operation per valid/ready handshake, clears the ALU, drives the
//  start/sel/inbus load protocol, waits for finish, and returns outbus plus overflow
//  on a valid/ready response port. Only one operation is in flight; no queuing.
// PARAMETERS
//  DATA_W   16  width of inbus/outbus and of the cmd_a and rsp_data fields
//  OPB_W     8  width of the second operand (M)
//  TIMEOUT  64  max cycles spent in WAIT before abort (used only with the macro)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       async active-high reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       high only in IDLE
//  cmd_op       in   2       00 add, 01 sub, 10 mul, 11 div (drives ALU sel)
//  cmd_a        in   DATA_W  first operand: A for add/sub, Q for mul, A.Q for div
//  cmd_b        in   OPB_W   second operand M
//  rsp_valid    out  1       response held until rsp_ready
//  rsp_ready    in   1       consumer accepts response
//  rsp_data     out  DATA_W  captured ALU outbus
//  rsp_of       out  1       sticky overflow seen during the operation
//  rsp_err      out  1       operation aborted by timeout (0 when macro absent)
//  alu_rst      out  1       synchronous clear pulse to the ALU
//  alu_start    out  1       ALU start
//  alu_sel      out  2       ALU sel
//  alu_inbus    out  DATA_W  ALU inbus
//  alu_finish   in   1       ALU finish
//  alu_outbus   in   DATA_W  ALU outbus
//  alu_of_flag  in   1       ALU overflow flag (pulse)
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0 except cmd_ready=1; latched op/operands cleared.
//  - Handshake: accept on cmd_valid & cmd_ready; latch op, a, b. Response: rsp_valid,
//    rsp_data, rsp_of and rsp_err are stable while rsp_valid & ~rsp_ready.
//  - FSM, one state per cycle unless noted:
//    IDLE -> CLR on accept. CLR: alu_rst=1.
//    LOADA: alu_start=1, alu_sel=op, alu_inbus = (op==11) ? a : {8'b0, a[7:0]}.
//    GAP: alu_start=0, alu_inbus held at LOADA value, alu_sel held.
//    LOADB: alu_inbus = {8'b0, b}; this value is held through WAIT.
//    WAIT: stays until alu_finish=1, then -> CAPT.
//    CAPT: rsp_data <= alu_outbus (one cycle after finish, so outbus is settled) -> RESP.
//    RESP: rsp_valid=1; on rsp_ready -> IDLE (cmd_ready=1 on the next cycle).
//  - alu_sel holds op from LOADA through CAPT; it is 0 in IDLE/CLR/RESP.
//  - rsp_of: cleared in CLR, OR-accumulates alu_of_flag in LOADB, WAIT and CAPT.
//  - Latency, accept to rsp_valid: 6 + (cycles in WAIT) cycles minimum.
//  - alu_finish outside WAIT is ignored; cmd_valid outside IDLE is ignored (not lost:
//    cmd_ready=0, so the sender must hold it).
//  - Reset mid-operation: FSM returns to IDLE at once; no response is produced.
// CONFIGURATION
//  ALU_SEQ_TIMEOUT_EN defined: a WAIT-cycle counter of clog2(TIMEOUT+1) bits is cleared
//   on WAIT entry. When it reaches TIMEOUT with finish still 0, go to CAPT with rsp_err=1
//   and rsp_data=0. rsp_err is cleared in CLR.
//  ALU_SEQ_TIMEOUT_EN undefined: WAIT never exits without finish; rsp_err is tied to 0.
// TESTING
//  1 add a=20 b=75 -> rsp_data=95, rsp_of=0; alu_start high exactly 1 cycle, alu_rst 1 cycle before.
//  2 add a=127 b=126 -> rsp_data[7:0]=8'hFD, rsp_of=1.
//  3 mul a=8'hE9(-23) b=75 -> rsp_data=16'hF943 (-1725), rsp_of=0.
//  4 div a=5771 b=135 -> rsp_data={8'd101,8'd42}=16'h652A; alu_inbus=5771 in LOADA and GAP.
//  5 rsp_ready held 0 for 10 cycles after rsp_valid -> response stable, cmd_ready=0,
//    a new cmd_valid is not accepted; rsp_ready=1 -> IDLE next cycle.
//  6 rst asserted in WAIT -> same cycle IDLE, rsp_valid=0; with macro and finish tied 0
//    -> rsp_err=1 after 64 WAIT cycles.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Upstream command sequencer for the 8-bit sequential ALU (add/sub/Booth
// mul/div). One operation is accepted per cmd valid/ready handshake. The
// sequencer then clears the ALU, walks it through its start/sel/inbus load
// protocol, waits for finish, and returns outbus plus a sticky overflow bit on
// a valid/ready response port. Only one operation is in flight at a time.
//
// Parameters
//   DATA_W   width of inbus/outbus, cmd_a and rsp_data
//   OPB_W    width of the second operand M (cmd_b)
//   TIMEOUT  maximum WAIT cycles before abort (only with the macro below)
//
// Optional feature
//   ALU_SEQ_TIMEOUT_EN  when defined, WAIT is abandoned after TIMEOUT cycles
//                       without finish; the response then carries rsp_err=1
//                       and rsp_data=0. When undefined, rsp_err is tied to 0
//                       and WAIT only exits on finish.
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b           operation code and operands
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_of, rsp_err      result, sticky overflow, timeout abort
//   alu_rst, alu_start, alu_sel,   drive side of the ALU load protocol
//   alu_inbus
//   alu_finish, alu_outbus,        ALU completion, result and overflow pulse
//   alu_of_flag
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int DATA_W  = 16,
  parameter int OPB_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [OPB_W-1:0]  cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_of,
  output logic              rsp_err,
  output logic              alu_rst,
  output logic              alu_start,
  output logic [1:0]        alu_sel,
  output logic [DATA_W-1:0] alu_inbus,
  input  logic              alu_finish,
  input  logic [DATA_W-1:0] alu_outbus,
  input  logic              alu_of_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOADA,
    S_GAP,
    S_LOADB,
    S_WAIT,
    S_CAPT,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_DIV = 2'b11;

  state_t              state;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   a_q;
  logic [OPB_W-1:0]    b_q;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  logic             err_q;

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Every output is registered: the value driven during a state is assigned
  // on the clock edge that enters it.
  // NOTE: state and outputs use non-blocking assignments so every register in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_of    <= 1'b0;
      alu_rst   <= 1'b0;
      alu_start <= 1'b0;
      alu_sel   <= '0;
      alu_inbus <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      wait_cnt  <= '0;
      timed_out <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      // NOTE: the two ALU strobes default low each cycle, so a state that
      // raises one produces a single-cycle pulse without an explicit clear.
      alu_rst   <= 1'b0;
      alu_start <= 1'b0;

      unique case (state)
        S_IDLE: begin
          // cmd_ready is 1 throughout IDLE, so cmd_valid alone is the accept.
          if (cmd_valid) begin
            op_q      <= cmd_op;
            a_q       <= cmd_a;
            b_q       <= cmd_b;
            cmd_ready <= 1'b0;
            alu_rst   <= 1'b1;
            state     <= S_CLR;
          end
        end

        S_CLR: begin
          rsp_of    <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
          timed_out <= 1'b0;
          err_q     <= 1'b0;
`endif
          alu_start <= 1'b1;
          alu_sel   <= op_q;
          // Divide loads the full A.Q dividend; the others load an 8-bit value.
          alu_inbus <= (op_q == OP_DIV) ? a_q : DATA_W'(a_q[7:0]);
          state     <= S_LOADA;
        end

        S_LOADA: begin
          state <= S_GAP;
        end

        S_GAP: begin
          alu_inbus <= DATA_W'(b_q);
          state     <= S_LOADB;
        end

        S_LOADB: begin
          rsp_of <= rsp_of | alu_of_flag;
`ifdef ALU_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state  <= S_WAIT;
        end

        S_WAIT: begin
          rsp_of <= rsp_of | alu_of_flag;
          if (alu_finish) begin
            state <= S_CAPT;
`ifdef ALU_SEQ_TIMEOUT_EN
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th cycle spent here without finish.
            timed_out <= 1'b1;
            state     <= S_CAPT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          end
        end

        S_CAPT: begin
          // Sampled one cycle after finish so the ALU outbus has settled.
          rsp_of    <= rsp_of | alu_of_flag;
`ifdef ALU_SEQ_TIMEOUT_EN
          rsp_data  <= timed_out ? '0 : alu_outbus;
          err_q     <= timed_out;
`else
          rsp_data  <= alu_outbus;
`endif
          rsp_valid <= 1'b1;
          alu_sel   <= '0;
          alu_inbus <= '0;
          state     <= S_RESP;
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          alu_sel   <= '0;
          alu_inbus <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Self-checking bench for alu_op_sequencer. A behavioural stand-in for the
// 8-bit ALU follows the load protocol, computes add/sub/mul/div from the
// operands it was actually given, and answers after a per-command latency.
// The driver pushes hand-computed expected responses into a queue; a separate
// monitor pops and compares whenever the sequencer presents a response.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int DATA_W = 16;
  localparam int OPB_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [OPB_W-1:0]  cmd_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_of;
  logic              rsp_err;
  logic              alu_rst;
  logic              alu_start;
  logic [1:0]        alu_sel;
  logic [DATA_W-1:0] alu_inbus;
  logic              alu_finish;
  logic [DATA_W-1:0] alu_outbus;
  logic              alu_of_flag;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .DATA_W  (DATA_W),
    .OPB_W   (OPB_W),
    .TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_of      (rsp_of),
    .rsp_err     (rsp_err),
    .alu_rst     (alu_rst),
    .alu_start   (alu_start),
    .alu_sel     (alu_sel),
    .alu_inbus   (alu_inbus),
    .alu_finish  (alu_finish),
    .alu_outbus  (alu_outbus),
    .alu_of_flag (alu_of_flag)
  );

  typedef struct {
    logic [15:0] data;
    logic        of;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   n_checks    = 0;
  int   n_pass      = 0;
  int   done_cnt    = 0;
  int   hold_cycles = 0;
  int   alu_phase   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // ALU stand-in, acting on falling edges.
  // phase 1 LOADA, 2 GAP, 3 LOADB, 4 waiting, 5 finished.
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0]        a_cap;
    logic [15:0]        res;
    logic [7:0]         m;
    logic [7:0]         r8;
    logic [1:0]         op;
    logic signed [7:0]  sa;
    logic signed [7:0]  sm;
    logic signed [15:0] prod;
    logic               ovf;
    int                 cnt;
    alu_finish  = 1'b0;
    alu_outbus  = '0;
    alu_of_flag = 1'b0;
    cnt         = 0;
    forever begin
      @(negedge clk);
      alu_of_flag = 1'b0;
      if (rst) begin
        alu_phase  = 0;
        alu_finish = 1'b0;
      end else if (alu_rst) begin
        check("start_during_clr", 32'(alu_start), 32'(0));
        alu_phase  = 1;
        alu_finish = 1'b0;
        alu_outbus = '0;
      end else begin
        case (alu_phase)
          1: begin
            check("start_after_clr", 32'(alu_start), 32'(1));
            a_cap     = alu_inbus;
            op        = alu_sel;
            cnt       = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            alu_phase = 2;
          end
          2: begin
            check("start_width", 32'(alu_start), 32'(0));
            check("inbus_gap", 32'(alu_inbus), 32'(a_cap));
            check("sel_gap", 32'(alu_sel), 32'(op));
            alu_phase = 3;
          end
          3: begin
            check("inbus_b_hi", 32'(alu_inbus[15:8]), 32'(0));
            m   = alu_inbus[7:0];
            ovf = 1'b0;
            case (op)
              2'b00: begin
                r8  = a_cap[7:0] + m;
                res = {8'h00, r8};
                ovf = (a_cap[7] == m[7]) && (r8[7] != a_cap[7]);
              end
              2'b01: begin
                r8  = a_cap[7:0] - m;
                res = {8'h00, r8};
                ovf = (a_cap[7] != m[7]) && (r8[7] != a_cap[7]);
              end
              2'b10: begin
                sa   = a_cap[7:0];
                sm   = m;
                prod = sa * sm;
                res  = prod;
              end
              default: begin
                if (m == 8'd0) res = 16'hFFFF;
                else res = {8'(a_cap % 16'(m)), 8'(a_cap / 16'(m))};
                ovf = (m != 8'd0) && ((a_cap / 16'(m)) > 16'd255);
              end
            endcase
            // Overflow is pulsed early so the sequencer has to hold it.
            alu_of_flag = ovf;
            alu_phase   = 4;
          end
          4: begin
            check("inbus_wait", 32'(alu_inbus), 32'({8'h00, m}));
            if (cnt == 0) begin
              alu_finish = 1'b1;
              alu_outbus = res;
              alu_phase  = 5;
            end else begin
              cnt--;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response monitor / scoreboard.
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail_bound("unexpected_rsp");
          e = '{16'h0000, 1'b0, 1'b0};
        end else begin
          e = exp_q.pop_front();
        end
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_of", 32'(rsp_of), 32'(e.of));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_cmd_ready", 32'(cmd_ready), 32'(0));
        check("rsp_sel", 32'(alu_sel), 32'(0));
        for (int i = 0; i < hold_cycles; i++) begin
          @(negedge clk);
          check("hold_valid", 32'(rsp_valid), 32'(1));
          check("hold_data", 32'(rsp_data), 32'(e.data));
          check("hold_of", 32'(rsp_of), 32'(e.of));
          check("hold_cmd_ready", 32'(cmd_ready), 32'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'(0));
        check("idle_ready", 32'(cmd_ready), 32'(1));
        done_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver. Called on a falling edge; returns on a falling edge.
  // ---------------------------------------------------------------------------
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b,
                      input int lat, input bit want_rsp,
                      input logic [15:0] d, input logic of, input logic err);
    int n;
    n         = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      fail_bound("accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    lat_q.push_back(lat);
    if (want_rsp) exp_q.push_back('{d, of, err});
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_ready_drop", 32'(cmd_ready), 32'(0));
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) fail_bound("rsp_timeout");
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'(1));
    check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    check("reset_rsp_data", 32'(rsp_data), 32'(0));
    check("reset_rsp_of", 32'(rsp_of), 32'(0));
    check("reset_alu_rst", 32'(alu_rst), 32'(0));
    check("reset_alu_start", 32'(alu_start), 32'(0));
    check("reset_alu_sel", 32'(alu_sel), 32'(0));
    check("reset_alu_inbus", 32'(alu_inbus), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // add 20+75, add with signed overflow, signed mul, div of a 16-bit dividend
    send(2'b00, 16'd20,    8'd75,  0, 1'b1, 16'd95,   1'b0, 1'b0);
    wait_done(1);
    send(2'b00, 16'd127,   8'd126, 3, 1'b1, 16'h00FD, 1'b1, 1'b0);
    wait_done(2);
    send(2'b10, 16'h00E9,  8'd75,  8, 1'b1, 16'hF943, 1'b0, 1'b0);
    wait_done(3);
    send(2'b11, 16'd5771,  8'd135, 5, 1'b1, 16'h652A, 1'b0, 1'b0);
    wait_done(4);

    // Back-pressured response; the next command is held pending meanwhile.
    // The add also shows that the upper byte of cmd_a is dropped.
    hold_cycles = 10;
    send(2'b00, 16'h5564,  8'd27,  2, 1'b1, 16'h007F, 1'b0, 1'b0);
    send(2'b01, 16'd10,    8'd20,  1, 1'b1, 16'h00F6, 1'b0, 1'b0);
    hold_cycles = 0;
    wait_done(6);

    // Reset while the sequencer is in WAIT: no response, outputs back to idle.
    send(2'b00, 16'd1, 8'd1, 40, 1'b0, 16'h0000, 1'b0, 1'b0);
    n = 0;
    while (alu_phase != 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (alu_phase != 4) fail_bound("reach_wait");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("midrst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("midrst_alu_sel", 32'(alu_sel), 32'(0));
    check("midrst_alu_inbus", 32'(alu_inbus), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(2'b01, 16'd5, 8'd7, 2, 1'b1, 16'h00FE, 1'b0, 1'b0);
    wait_done(7);

`ifdef ALU_SEQ_TIMEOUT_EN
    // The stand-in answers far too late; the sequencer must abort.
    send(2'b00, 16'd20, 8'd75, 200, 1'b1, 16'h0000, 1'b0, 1'b1);
    wait_done(8);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
